// File: rtl/mux_n_rr_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared mode encoding and modulo index helper for mux_n_rr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Wraps to zero after the last channel, so non-power-of-2 counts work.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned channels);
    return ((idx + 32'd1) >= channels) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_rr_if.sv
// ============================================================================
// Module      : mux_n_rr_if
// Description : Stream bundle for mux_n_rr: N input channels, one output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_n_rr_if #(
  parameter int unsigned WIDTH    = 21,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;

  // Producers/consumer side
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

  // Multiplexer side
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

endinterface

`default_nettype wire

// File: rtl/mux_n_rr_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  wire logic [CHANNELS-1:0] req,
  input  wire logic [SEL_W-1:0]    ptr,
  input  wire logic                en,
  output logic      [SEL_W-1:0]    grant_idx,
  output logic                     grant_vld
);

  logic [SEL_W-1:0] w_idx;

  // Visits ptr+1 .. ptr (wrapping), so ptr itself has lowest priority.
  always_comb begin
    w_idx     = ptr;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_idx = SEL_W'(next_idx(32'(w_idx), CHANNELS));
      if (en && !grant_vld && req[w_idx]) begin
        grant_vld = 1'b1;
        grant_idx = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_rr.sv
// ============================================================================
// Module      : mux_n_rr
// Description : Registered N-to-1 stream mux, fixed-index or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_rr
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 21,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             mode,
  input  wire logic [SEL_W-1:0] sel,
  mux_n_rr_if.slave             bus
);

  localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(CHANNELS - 1);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_ch;
  logic [SEL_W-1:0]    r_ptr;

  mux_mode_e           w_mode;
  logic                w_load;
  logic                w_fix_vld;
  logic                w_rr_vld;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_ready;
  logic [WIDTH-1:0]    w_data;

  assign w_mode    = mux_mode_e'(mode);
  assign w_load    = !r_out_valid || bus.out_ready;
  assign w_fix_vld = (32'(sel) < CHANNELS) && bus.in_valid[sel];

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (r_ptr),
    .en        (w_mode == MODE_RR),
    .grant_idx (w_rr_idx),
    .grant_vld (w_rr_vld)
  );

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    case (w_mode)
      MODE_FIXED: begin
        w_grant_vld = w_fix_vld;
        w_grant_idx = sel;
      end
      MODE_RR: begin
        w_grant_vld = w_rr_vld;
        w_grant_idx = w_rr_idx;
      end
      default: begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
      end
    endcase
  end

  // Reset gates the transfer so nothing is offered while rst is high.
  assign w_xfer = w_load && w_grant_vld && !rst;

  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_ready[i] = w_xfer && (w_grant_idx == SEL_W'(i));
      if (w_grant_idx == SEL_W'(i)) begin
        w_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= c_ptr_rst;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_grant_idx;
      r_ptr       <= w_grant_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_rr.sv
// ============================================================================
// Module      : tb_mux_n_rr
// Description : Directed and random checks of mux_n_rr against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_n_rr;

  localparam int unsigned WIDTH    = 21;
  localparam int unsigned CHANNELS = 4;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] dat [CHANNELS];

  // Reference state of the output register and fairness pointer
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_ch;
  int               m_ptr;

  mux_n_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  mux_n_rr #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < CHANNELS; i++) bus.in_data[i*WIDTH +: WIDTH] = dat[i];
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (mode == 1'b0) begin
      if (bus.in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        int c;
        c = (m_ptr + k) % CHANNELS;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    return g;
  endfunction

  // Compare, then advance the model across one rising edge
  task automatic cycle();
    int         g;
    logic       load;
    logic [3:0] er;
    #1;
    load = !m_valid || bus.out_ready;
    g    = model_grant();
    er   = 4'b0000;
    if (!rst && load && g >= 0) er = 4'b0001 << g;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_data",  64'(bus.out_data),  64'(m_data));
    chk("out_ch",    64'(bus.out_ch),    64'(m_ch));
    chk("in_ready",  64'(bus.in_ready),  64'(er));
    @(posedge clk);
    if (er != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = dat[g];
      m_ch    = 2'(g);
      m_ptr   = g;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 2'd0;
    m_ptr   = CHANNELS - 1;
  endtask

  // Pulse rst between edges and check the immediate clear
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_ch",    64'(bus.out_ch),    64'd0);
    chk("rst_ready", 64'(bus.in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         rr_seq [6];
    logic [3:0] onehot;
    rr_seq = '{0, 1, 2, 3, 0, 1};

    rst           = 1'b1;
    mode          = 1'b0;
    sel           = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) dat[i] = WIDTH'(i + 1);
    drive_data();
    model_reset();

    #2;
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_data",  64'(bus.out_data),  64'd0);
    chk("reset_ch",    64'(bus.out_ch),    64'd0);
    chk("reset_ready", 64'(bus.in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed mode, step sel through every channel
    for (int s = 0; s < CHANNELS; s++) begin
      sel = 2'(s);
      #1;
      onehot = 4'b0001 << s;
      chk("fix_ready", 64'(bus.in_ready), 64'(onehot));
      cycle();
      chk("fix_data", 64'(bus.out_data), 64'(s + 1));
      chk("fix_ch",   64'(bus.out_ch),   64'(s));
    end

    // Round-robin fairness from reset
    async_reset();
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_ch",    64'(bus.out_ch),    64'(rr_seq[i]));
      chk("rr_valid", 64'(bus.out_valid), 64'd1);
    end

    // Round-robin skips idle channels
    async_reset();
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("skip_ch",    64'(bus.out_ch), (i % 2 == 1) ? 64'd3 : 64'd1);
      chk("skip_ready", 64'(bus.in_ready & 4'b0101), 64'd0);
    end

    // Backpressure holds the beat, then resumes with the next channel
    async_reset();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_first", 64'(bus.out_data), 64'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_data",  64'(bus.out_data),  64'd1);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_next_ch",   64'(bus.out_ch),   64'd1);
    chk("bp_next_data", 64'(bus.out_data), 64'd2);

    // Fixed-mode miss: selected channel idle
    mode         = 1'b0;
    sel          = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    chk("miss_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    chk("miss_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while a beat is held
    mode         = 1'b1;
    bus.in_valid = 4'b1111;
    cycle();
    cycle();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    async_reset();
    cycle();
    chk("post_rst_ch",    64'(bus.out_ch),    64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(63) == 0) async_reset();
      mode          = 1'($urandom_range(1));
      sel           = 2'($urandom_range(3));
      bus.in_valid  = 4'($urandom_range(15));
      bus.out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < CHANNELS; i++) dat[i] = WIDTH'($urandom);
      drive_data();
      cycle();
    end
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised, registered N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output. It succeeds the combinational 4:1 datapath mux. Channel count, width and selection mode are generalised:
- Fixed mode selects the channel given by an index.
- Round-robin mode arbitrates fairly among valid channels.

It sits between multiple producers in the processor pipeline (e.g. writeback sources, memory-return paths) and a single consumer, and registers the output to break the combinational path.

## Interface
Parameters:
- WIDTH, 21, data width per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), select/index width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  CHANNELS*WIDTH  packed inputs, channel i at [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready, one-hot or zero
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used in fixed mode
- out_data  out  WIDTH  registered selected data
- out_ch  out  SEL_W  index of the channel that out_data came from
- out_valid  out  1  output holds a beat
- out_ready  in  1  consumer accepts the beat

## Operation
- **Load condition:** `load = !out_valid || out_ready`. The output register accepts a new beat only when load is true.
- **Grant, fixed mode:** grant channel `sel` iff `in_valid[sel]` and `sel < CHANNELS`. Otherwise there is no grant.
- **Grant, round-robin mode:**
  - Search order is ptr+1, ptr+2, … wrapping modulo CHANNELS, ending at ptr.
  - The first valid channel in that order is granted.
- **in_ready:** `in_ready[g] = load && grant valid`. All other bits are 0. in_ready never depends on in_valid of other channels in fixed mode.
- **Transfer:** occurs on channel g when `in_valid[g] && in_ready[g]`. On that edge: out_data ← in_data[g], out_ch ← g, out_valid ← 1.
- **Output drain:** if out_valid && out_ready and there is no transfer, out_valid ← 0. out_data and out_ch hold their last values.
- **Output stall:** out_valid && !out_ready means out_data and out_ch are frozen and all in_ready are 0.
- **Round-robin pointer:**
  - ptr ← g on every transfer, in either mode, so switching to round-robin continues fairly.
  - ptr is unchanged when there is no transfer.
- **Mode/sel changes:** sampled every cycle combinationally. A change never alters a beat already held in the output register.
- **Arithmetic:** pointer wrap uses modulo CHANNELS (non-power-of-2 CHANNELS supported). No width truncation of data.

## Timing
- **Latency:** 1 cycle from input transfer edge to out_valid.
- **Throughput:** 1 beat/cycle when out_ready is held high (simultaneous drain and load in the same cycle).
- **Reset values:** out_valid=0, out_data=0, out_ch=0, ptr=CHANNELS-1 (channel 0 has first round-robin priority).
- **in_ready during reset:** 0 while rst is high.
- **Reset mid-operation:**
  - Asynchronous clear of any held beat; the beat is lost and is not replayed.
  - After release, the first grant follows the reset pointer.
- **All in_valid low:** no grant, in_ready=0, out_valid drains normally.
- **Single valid channel in round-robin mode:** granted every cycle regardless of ptr.
- **Simultaneous drain and load:** the new beat replaces the old one in the same edge, with no bubble.

## Structure
- **Package mux_pkg:** mux_mode_e enum (MODE_FIXED=1'b0, MODE_RR=1'b1) and the helper function `next_idx(idx, CHANNELS)` for modulo wrap.
- **Sub-module rr_arbiter:**
  - Parameter CHANNELS.
  - Inputs: req, ptr, en. Outputs: grant_idx, grant_vld.
  - Purely combinational priority search from ptr+1.
- **mux_n_rr top:** owns the output register, ptr register, mode/sel handling and ready generation.

## Test plan
All scenarios use WIDTH=21, CHANNELS=4, channel i data = i+1.
- **Fixed mode, sel 00..11:**
  - Stimulus: all in_valid=1, out_ready=1, step sel through 00, 01, 10, 11.
  - Required: out_data = 1, 2, 3, 4 and out_ch = sel, each one cycle after sel changes; in_ready one-hot at sel.
- **Round-robin fairness:**
  - Stimulus: all valid, out_ready=1, mode=1 from reset.
  - Required: out_ch sequence 0, 1, 2, 3, 0, 1, one beat per cycle.
- **Round-robin skip:**
  - Stimulus: in_valid=4'b1010.
  - Required: out_ch alternates 1, 3, 1, 3; in_ready[0] and in_ready[2] never asserted.
- **Backpressure:**
  - Stimulus: out_ready=0 for 3 cycles after the first beat.
  - Required: out_data=1 held, out_valid=1, in_ready=0000.
  - On release, the next beat is out_ch=1 and no beat is lost or duplicated.
- **Fixed-mode miss:**
  - Stimulus: sel=10, in_valid[2]=0, others 1.
  - Required: in_ready=0000 and out_valid falls after drain.
- **Async reset mid-stream:**
  - Stimulus: assert rst between clock edges while out_valid=1.
  - Required: out_valid=0, out_data=0 immediately.
  - After release in round-robin with all valid, the first out_ch=0.
